// File: rtl/mpu_matrix_loader_pkg.sv
// Shared definitions for the matrix load path: sizes, float element type,
// loader FSM states and the element-stage payload.
package mpu_matrix_loader_pkg;

    // Matrix geometry and register file addressing
    localparam int unsigned M               = 4;
    localparam int unsigned N               = 4;
    localparam int unsigned MBITS           = 2;
    localparam int unsigned NBITS           = 2;
    localparam int unsigned MATRIX_REG_BITS = 2;

    // IEEE-754 single precision element
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_sp;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } loader_state_t;

    // One element with its matrix coordinates
    typedef struct packed {
        float_sp          elem;
        logic [MBITS:0]   i;
        logic [NBITS:0]   j;
    } elem_entry_t;

endpackage

// File: rtl/mpu_elem_stage.sv
// One-entry valid/ready register holding an element and its (i,j) location.
// Accepting and draining in the same cycle overwrites the entry, so the
// stage sustains one element per clock.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   in_valid        upstream offers in_data
//   in_data         element + coordinates
//   in_ready_c      stage can take in_data this cycle (combinational)
//   out_valid       entry holds data
//   out_data        held entry (stable while out_ready=0)
//   out_ready       downstream consumes the entry this cycle
module mpu_elem_stage
    import mpu_matrix_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  elem_entry_t in_data,
    output logic        in_ready_c,
    output logic        out_valid,
    output elem_entry_t out_data,
    input  logic        out_ready
);

    assign in_ready_c = ~out_valid | out_ready;

    // Entry register: load wins over drain so a same-cycle retire+accept refills
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready_c) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Matrix load initiator: accepts one load command (destination register,
// MxN size), pulls row-major elements from a valid/ready memory stream and
// writes them one per cycle into the matrix register file load port.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   ld_req_in/addr/m/n        load command (sampled in IDLE only)
//   ld_busy_out               command in progress
//   ld_done_out               one-cycle pulse after the last write retires
//   ld_error_out              one-cycle pulse when a command is rejected
//   mem_valid_in/element_in   memory element stream
//   mem_ready_out             element accepted this cycle when valid
//   reg_load_*                register file write port
//   load_ready_in             register file accepts the write this cycle
module mpu_matrix_loader
    import mpu_matrix_loader_pkg::*;
#(
    parameter int unsigned M_MAX = M,
    parameter int unsigned N_MAX = N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_req_in,
    input  logic [MATRIX_REG_BITS:0]   ld_req_addr_in,
    input  logic [MBITS:0]             ld_req_m_in,
    input  logic [NBITS:0]             ld_req_n_in,
    output logic                       ld_busy_out,
    output logic                       ld_done_out,
    output logic                       ld_error_out,
    input  logic                       mem_valid_in,
    input  float_sp                    mem_element_in,
    output logic                       mem_ready_out,
    output logic                       reg_load_en_out,
    output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out,
    output float_sp                    reg_load_element_out,
    input  logic                       load_ready_in
);

    localparam int unsigned MW = MBITS + 1;
    localparam int unsigned NW = NBITS + 1;

    loader_state_t state, next_state;

    logic          start_c;
    logic          error_c;
    logic          req_ok_c;
    logic          accept_c;
    logic [MBITS:0] ia;
    logic [NBITS:0] ja;
    logic          all_accepted;

    logic          stage_in_ready_c;
    logic          stage_valid;
    elem_entry_t   stage_in;
    elem_entry_t   stage_out;

    // Size check against the configured maxima
    assign req_ok_c = (ld_req_m_in != '0) && (ld_req_m_in <= MW'(M_MAX)) &&
                      (ld_req_n_in != '0) && (ld_req_n_in <= NW'(N_MAX));

    assign mem_ready_out = (state == LD_LOAD) & ~all_accepted & stage_in_ready_c;
    assign accept_c      = mem_valid_in & mem_ready_out;

    always_comb begin
        stage_in      = '0;
        stage_in.elem = mem_element_in;
        stage_in.i    = ia;
        stage_in.j    = ja;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; LOAD ends once everything is accepted and the stage drains
    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        error_c    = 1'b0;
        case (state)
            LD_IDLE: begin
                if (ld_req_in) begin
                    if (req_ok_c) begin
                        start_c    = 1'b1;
                        next_state = LD_LOAD;
                    end else begin
                        error_c    = 1'b1;
                    end
                end
            end
            LD_LOAD: begin
                if (all_accepted && (!stage_valid || load_ready_in)) begin
                    next_state = LD_DONE;
                end
            end
            LD_DONE: begin
                next_state = LD_IDLE;
            end
            default: begin
                next_state = LD_IDLE;
            end
        endcase
    end

    // Status pulses, command latch and accept counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_busy_out         <= 1'b0;
            ld_done_out         <= 1'b0;
            ld_error_out        <= 1'b0;
            reg_load_addr_out   <= '0;
            reg_m_load_size_out <= '0;
            reg_n_load_size_out <= '0;
            ia                  <= '0;
            ja                  <= '0;
            all_accepted        <= 1'b0;
        end else begin
            ld_busy_out  <= (next_state == LD_LOAD);
            ld_done_out  <= (next_state == LD_DONE);
            ld_error_out <= error_c;
            if (start_c) begin
                reg_load_addr_out   <= ld_req_addr_in;
                reg_m_load_size_out <= ld_req_m_in;
                reg_n_load_size_out <= ld_req_n_in;
                ia                  <= '0;
                ja                  <= '0;
                all_accepted        <= 1'b0;
            end else if (accept_c) begin
                // Row-major walk; wrap uses the latched size minus one
                if (ja == reg_n_load_size_out - NW'(1)) begin
                    ja <= '0;
                    if (ia == reg_m_load_size_out - MW'(1)) begin
                        all_accepted <= 1'b1;
                    end else begin
                        ia <= ia + MW'(1);
                    end
                end else begin
                    ja <= ja + NW'(1);
                end
            end
        end
    end

    mpu_elem_stage u_stage (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (accept_c),
        .in_data    (stage_in),
        .in_ready_c (stage_in_ready_c),
        .out_valid  (stage_valid),
        .out_data   (stage_out),
        .out_ready  (load_ready_in)
    );

    assign reg_load_en_out      = stage_valid;
    assign reg_i_load_loc_out   = stage_out.i;
    assign reg_j_load_loc_out   = stage_out.j;
    assign reg_load_element_out = stage_out.elem;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: table of commands, randomized
// commands and directed multi-cycle sequences against a row-major model.
module tb_mpu_matrix_loader;
    import mpu_matrix_loader_pkg::*;

    logic                     clk;
    logic                     rst;
    logic                     ld_req;
    logic [MATRIX_REG_BITS:0] ld_addr;
    logic [MBITS:0]           ld_m;
    logic [NBITS:0]           ld_n;
    logic                     busy, done, error;
    logic                     mem_valid;
    float_sp                  mem_elem;
    logic                     mem_ready;
    logic                     reg_en;
    logic [MATRIX_REG_BITS:0] reg_addr;
    logic [MBITS:0]           reg_i, reg_m;
    logic [NBITS:0]           reg_j, reg_n;
    float_sp                  reg_elem;
    logic                     load_ready;

    int checks = 0;
    int errors = 0;

    mpu_matrix_loader dut (
        .clk                  (clk),
        .rst                  (rst),
        .ld_req_in            (ld_req),
        .ld_req_addr_in       (ld_addr),
        .ld_req_m_in          (ld_m),
        .ld_req_n_in          (ld_n),
        .ld_busy_out          (busy),
        .ld_done_out          (done),
        .ld_error_out         (error),
        .mem_valid_in         (mem_valid),
        .mem_element_in       (mem_elem),
        .mem_ready_out        (mem_ready),
        .reg_load_en_out      (reg_en),
        .reg_load_addr_out    (reg_addr),
        .reg_i_load_loc_out   (reg_i),
        .reg_j_load_loc_out   (reg_j),
        .reg_m_load_size_out  (reg_m),
        .reg_n_load_size_out  (reg_n),
        .reg_load_element_out (reg_elem),
        .load_ready_in        (load_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
        chk({tag, "_en"}, 32'(reg_en), 32'd0);
        chk({tag, "_addr"}, 32'(reg_addr), 32'd0);
        chk({tag, "_ij"}, 32'({reg_i, reg_j}), 32'd0);
        chk({tag, "_mn"}, 32'({reg_m, reg_n}), 32'd0);
        chk({tag, "_elem"}, 32'(reg_elem), 32'd0);
    endtask

    // Issues one command and plays the memory / register-file sides.
    // vmode: 0 random valid by vpct, 1 valid on even cycles only.
    // rmode: 0 random ready by rpct, 1 ready low 3 cycles after 2nd write.
    // Expected k-th write is (k / n, k % n, elems[k]) at the command's addr/m/n.
    task automatic run_cmd(input string tag,
                           input logic [MATRIX_REG_BITS:0] addr,
                           input logic [MBITS:0] m, input logic [NBITS:0] n,
                           input int vpct, input int rpct, input int vmode, input int rmode,
                           input bit exp_err, input bit inject, input bit use_fixed,
                           input int abort_after,
                           output int first_wr, output int last_wr);
        logic [31:0] elems[$];
        logic [31:0] fixed_vals[4];
        int total, ptr, wr, stall_left;
        bit held, finished;
        logic [31:0] held_elem;
        logic [MBITS:0] held_i;
        logic [NBITS:0] held_j;
        fixed_vals = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
        first_wr = -1; last_wr = -1;
        total = int'(m) * int'(n);
        elems.delete();
        for (int k = 0; k < total; k++)
            elems.push_back((use_fixed && k < 4) ? fixed_vals[k] : $urandom);
        ld_req = 1'b1; ld_addr = addr; ld_m = m; ld_n = n;
        mem_valid = 1'b0; load_ready = 1'b1;
        @(negedge clk);
        ld_req = 1'b0;
        chk({tag, "_error_pulse"}, 32'(error), 32'(exp_err));
        chk({tag, "_busy_start"}, 32'(busy), 32'(!exp_err));
        if (exp_err) begin
            chk({tag, "_err_no_en"}, 32'(reg_en), 32'd0);
            @(negedge clk);
            chk({tag, "_err_one_pulse"}, 32'(error), 32'd0);
            chk({tag, "_err_busy"}, 32'(busy), 32'd0);
            chk({tag, "_err_no_en2"}, 32'(reg_en), 32'd0);
            return;
        end
        ptr = 0; wr = 0; stall_left = 0; held = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            if (vmode == 1) mem_valid = (ptr < total) && (cyc % 2 == 0);
            else            mem_valid = (ptr < total) && (int'($urandom_range(0, 99)) < vpct);
            mem_elem = float_sp'(mem_valid ? elems[ptr] : $urandom);
            if (stall_left > 0) load_ready = 1'b0;
            else if (rmode == 1) load_ready = 1'b1;
            else load_ready = int'($urandom_range(0, 99)) < rpct;
            ld_req = inject && (cyc == 3);
            ld_addr = ~addr; ld_m = 3'd1; ld_n = 3'd1;
            #1;
            if (stall_left > 0)
                chk({tag, "_stall_mem_ready"}, 32'(mem_ready), 32'd0);
            if (held) begin
                chk({tag, "_hold_en"}, 32'(reg_en), 32'd1);
                chk({tag, "_hold_data"}, {reg_elem}, held_elem);
                chk({tag, "_hold_ij"}, 32'({reg_i, reg_j}), 32'({held_i, held_j}));
            end
            if (mem_valid && mem_ready) ptr++;
            if (reg_en && load_ready) begin
                chk({tag, "_i"}, 32'(reg_i), 32'(wr / int'(n)));
                chk({tag, "_j"}, 32'(reg_j), 32'(wr % int'(n)));
                chk({tag, "_elem"}, reg_elem, elems[wr]);
                chk({tag, "_addr_mn"}, 32'({reg_addr, reg_m, reg_n}), 32'({addr, m, n}));
                if (vmode == 1) chk({tag, "_bubble_phase"}, 32'(cyc % 2), 32'd1);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                wr++;
                if (wr == total) finished = 1'b1;
            end
            if (stall_left > 0) stall_left--;
            else if (rmode == 1 && wr == 2 && reg_en && load_ready) stall_left = 3;
            held = reg_en && !load_ready;
            held_elem = reg_elem; held_i = reg_i; held_j = reg_j;
            @(negedge clk);
            if (abort_after > 0 && wr == abort_after) begin
                ld_req = 1'b0; mem_valid = 1'b0;
                return;
            end
        end
        ld_req = 1'b0; mem_valid = 1'b0; load_ready = 1'b1;
        if (!finished) begin
            errors++;
            $display("FAIL %s_timeout writes=%0d expected=%0d", tag, wr, total);
            return;
        end
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_no_en"}, 32'(reg_en), 32'd0);
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [MATRIX_REG_BITS:0] addr;
        logic [MBITS:0]           m;
        logic [NBITS:0]           n;
        int                       vpct;
        int                       rpct;
        bit                       exp_err;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int fw, lw;
        logic [MBITS:0] rm;
        logic [NBITS:0] rn;
        rst = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_m = '0; ld_n = '0;
        mem_valid = 1'b0; mem_elem = '0; load_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // 1: 2x2 full throughput, exact timing
        run_cmd("t1", 3'd1, 3'd2, 3'd2, 100, 100, 0, 0, 1'b0, 1'b0, 1'b1, 0, fw, lw);
        chk("t1_first_write_cycle", 32'(fw), 32'd1);
        chk("t1_last_write_cycle", 32'(lw), 32'd4);

        // 2: 3x3 with a 3-cycle register-file stall after the 2nd write
        run_cmd("t2", 3'd2, 3'd3, 3'd3, 100, 100, 0, 1, 1'b0, 1'b0, 1'b0, 0, fw, lw);

        // 3: 2x3 with memory bubbles every other cycle
        run_cmd("t3", 3'd3, 3'd2, 3'd3, 100, 100, 1, 0, 1'b0, 1'b0, 1'b0, 0, fw, lw);

        // 6: request during LOAD is ignored
        run_cmd("t6", 3'd5, 3'd3, 3'd2, 100, 100, 0, 0, 1'b0, 1'b1, 1'b0, 0, fw, lw);

        // Table: size boundaries and mixed handshake rates
        vecs.push_back('{3'd3, 3'd0, 3'd2, 100, 100, 1'b1});
        vecs.push_back('{3'd2, 3'd2, 3'd5, 100, 100, 1'b1});
        vecs.push_back('{3'd1, 3'd5, 3'd1, 100, 100, 1'b1});
        vecs.push_back('{3'd0, 3'd0, 3'd0, 100, 100, 1'b1});
        vecs.push_back('{3'd5, 3'd4, 3'd4,  70,  60, 1'b0});
        vecs.push_back('{3'd6, 3'd1, 3'd4,  50,  50, 1'b0});
        vecs.push_back('{3'd7, 3'd4, 3'd1,  90,  30, 1'b0});
        vecs.push_back('{3'd0, 3'd3, 3'd2, 100, 100, 1'b0});
        vecs.push_back('{3'd4, 3'd1, 3'd1, 100, 100, 1'b0});
        foreach (vecs[k])
            run_cmd($sformatf("tab%0d", k), vecs[k].addr, vecs[k].m, vecs[k].n,
                    vecs[k].vpct, vecs[k].rpct, 0, 0, vecs[k].exp_err, 1'b0, 1'b0, 0, fw, lw);

        // Randomized commands, legality decided from the size rule
        for (int r = 0; r < 10; r++) begin
            rm = 3'($urandom_range(0, 5));
            rn = 3'($urandom_range(0, 5));
            run_cmd($sformatf("rnd%0d", r), 3'($urandom), rm, rn,
                    int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, 0,
                    (rm == 0 || rm > 3'(M) || rn == 0 || rn > 3'(N)), 1'b0, 1'b0, 0, fw, lw);
        end

        // 5: reset after 5 of 9 writes, then a fresh 1x1 load
        run_cmd("t5a", 3'd6, 3'd3, 3'd3, 100, 100, 0, 0, 1'b0, 1'b0, 1'b0, 5, fw, lw);
        rst = 1'b0; load_ready = 1'b1;
        @(negedge clk);
        chk_all_zero("t5_reset");
        rst = 1'b1;
        @(negedge clk);
        chk("t5_idle_after_reset", 32'({busy, done, reg_en}), 32'd0);
        run_cmd("t5b", 3'd0, 3'd1, 3'd1, 100, 100, 0, 0, 1'b0, 1'b0, 1'b0, 0, fw, lw);
        chk("t5b_write_cycle", 32'(fw), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
